imem_loader: RTL

Boot-time program loader that writes the instruction memory. It accepts a byte stream (count header, little-endian instruction words, XOR checksum), assembles 32-bit words and issues one write per word to the instruction memory's write port. It holds the CPU pipeline in reset until a checksum-verified image is in place. It sits between the serial receiver and the instruction memory, replacing the hard-coded initial image.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Boot-loader bus bundle: byte stream in, instruction-memory write port and status out.
// The master side is the host/serial receiver; the slave side is the loader itself.
interface imem_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, error
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses count header, LE words and an XOR checksum,
// writes one word per memory strobe and keeps the core in reset until a verified image is in place.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_WORD  = 0
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  // Largest word count that still fits between BASE_WORD and the top of memory.
  localparam logic [31:0] MAX_WORDS = 32'((1 << ADDR_WIDTH) - BASE_WORD);

  state_t      state_reg;
  logic [1:0]  byte_cnt_reg;
  logic [15:0] word_cnt_reg;
  logic [15:0] count_reg;
  logic [7:0]  len_lo_reg;
  logic [7:0]  csum_reg;
  logic [23:0] acc_reg;
  logic        mem_we_reg;
  logic [31:0] mem_waddr_reg;
  logic [31:0] mem_wdata_reg;

  logic        accept;
  logic [15:0] len_full;
  logic [31:0] word_addr;

  assign bus.rx_ready = (state_reg == LEN0) || (state_reg == LEN1) ||
                        (state_reg == DATA) || (state_reg == CSUM);
  assign bus.busy     = bus.rx_ready;
  assign bus.done     = (state_reg == DONE);
  assign bus.error    = (state_reg == ERR);
  assign bus.cpu_hold = (state_reg != DONE);

  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_waddr = mem_waddr_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign len_full  = {bus.rx_data, len_lo_reg};
  assign word_addr = (32'(BASE_WORD) + {16'd0, word_cnt_reg}) << 2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      byte_cnt_reg  <= 2'd0;
      word_cnt_reg  <= 16'd0;
      count_reg     <= 16'd0;
      len_lo_reg    <= 8'd0;
      csum_reg      <= 8'd0;
      acc_reg       <= 24'd0;
      mem_we_reg    <= 1'b0;
      mem_waddr_reg <= 32'd0;
      mem_wdata_reg <= 32'd0;
    end else begin
      mem_we_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            state_reg    <= LEN0;
            byte_cnt_reg <= 2'd0;
            word_cnt_reg <= 16'd0;
            csum_reg     <= 8'd0;
          end
        end
        LEN0: begin
          if (accept) begin
            len_lo_reg <= bus.rx_data;
            state_reg  <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            count_reg <= len_full;
            if ((len_full == 16'd0) || ({16'd0, len_full} > MAX_WORDS))
              state_reg <= ERR;
            else
              state_reg <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            csum_reg     <= csum_reg ^ bus.rx_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              // Top byte arrives straight from the stream so the write issues next cycle.
              mem_we_reg    <= 1'b1;
              mem_waddr_reg <= word_addr;
              mem_wdata_reg <= {bus.rx_data, acc_reg};
              word_cnt_reg  <= word_cnt_reg + 16'd1;
              if (word_cnt_reg == count_reg - 16'd1)
                state_reg <= CSUM;
            end else begin
              acc_reg[{byte_cnt_reg, 3'b000} +: 8] <= bus.rx_data;
            end
          end
        end
        CSUM: begin
          if (accept)
            state_reg <= (bus.rx_data == csum_reg) ? DONE : ERR;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
